// File: rtl/xpt_step_sequencer.sv
// T-step sequencer: owns the XPT step counter and the latched opcode (Source).
// Runs the CM1 fetch phase, then enables the per-opcode decoders for execution.
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   Wait                - freezes the sequencer while high
//   DataBus[7:0]        - opcode byte, captured at XPT == LATCH_STEP
//   PR_Reset_XPT        - decoder strobe: XPT to 0, stay in EXEC
//   P2_Set_CM1          - decoder strobe: XPT to 0, start a fetch
//   XPT/notXPT[4:0]     - current step, true and complement
//   Source/notSource    - latched opcode, true and complement
//   CM1, enable, Fault  - FETCH, EXEC and FAULT state flags
module xpt_step_sequencer #(
    parameter int         XPT_WIDTH    = 5,
    parameter int         FETCH_LAST   = 3,
    parameter int         LATCH_STEP   = 2,
    parameter logic [7:0] RESET_OPCODE = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Wait,
    input  logic [7:0]           DataBus,
    input  logic                 PR_Reset_XPT,
    input  logic                 P2_Set_CM1,
    output logic [XPT_WIDTH-1:0] XPT,
    output logic [XPT_WIDTH-1:0] notXPT,
    output logic [7:0]           Source,
    output logic [7:0]           notSource,
    output logic                 CM1,
    output logic                 enable,
    output logic                 Fault
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [XPT_WIDTH-1:0] XPT_LATCH = XPT_WIDTH'(LATCH_STEP);
    localparam logic [XPT_WIDTH-1:0] XPT_FLAST = XPT_WIDTH'(FETCH_LAST);
    localparam logic [XPT_WIDTH-1:0] XPT_EXEC0 = XPT_WIDTH'(FETCH_LAST + 1);
    localparam logic [XPT_WIDTH-1:0] XPT_MAX   = '1;

    state_t               state_q, state_d;
    logic [XPT_WIDTH-1:0] xpt_q, xpt_d;
    logic [7:0]           src_q, src_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            xpt_q   <= '0;
            src_q   <= RESET_OPCODE;
        end else begin
            state_q <= state_d;
            xpt_q   <= xpt_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        xpt_d   = xpt_q;
        src_d   = src_q;
        // Wait freezes everything; strobes stay asserted by the
        // decoders (XPT is frozen) and are taken after Wait drops.
        if (!Wait) begin
            unique case (state_q)
                FETCH: begin
                    if (xpt_q == XPT_LATCH) begin
                        src_d = DataBus;
                    end
                    if (xpt_q == XPT_FLAST) begin
                        xpt_d   = XPT_EXEC0;
                        state_d = EXEC;
                    end else begin
                        xpt_d = xpt_q + 1'b1;
                    end
                end
                EXEC: begin
                    if (PR_Reset_XPT || P2_Set_CM1) begin
                        xpt_d = '0;
                        if (P2_Set_CM1) begin
                            state_d = FETCH;
                        end
                    end else if (xpt_q == XPT_MAX) begin
                        // Never wrap by counting: a runaway
                        // sequence is trapped until reset.
                        state_d = FAULT;
                    end else begin
                        xpt_d = xpt_q + 1'b1;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = FAULT;
                end
            endcase
        end
    end

    assign XPT       = xpt_q;
    assign notXPT    = ~xpt_q;
    assign Source    = src_q;
    assign notSource = ~src_q;
    assign CM1       = (state_q == FETCH);
    assign enable    = (state_q == EXEC);
    assign Fault     = (state_q == FAULT);

endmodule

// File: tb/tb_xpt_step_sequencer.sv
// Bench for xpt_step_sequencer: reference model feeds a scoreboard
// queue each cycle, plus directed checks on the key sequence points.
module tb_xpt_step_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       Wait;
    logic [7:0] DataBus;
    logic       PR_Reset_XPT;
    logic       P2_Set_CM1;
    logic [4:0] XPT;
    logic [4:0] notXPT;
    logic [7:0] Source;
    logic [7:0] notSource;
    logic       CM1;
    logic       enable;
    logic       Fault;

    xpt_step_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .Wait         (Wait),
        .DataBus      (DataBus),
        .PR_Reset_XPT (PR_Reset_XPT),
        .P2_Set_CM1   (P2_Set_CM1),
        .XPT          (XPT),
        .notXPT       (notXPT),
        .Source       (Source),
        .notSource    (notSource),
        .CM1          (CM1),
        .enable       (enable),
        .Fault        (Fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] xpt;
        logic [7:0] src;
        logic       cm1;
        logic       en;
        logic       flt;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    // reference model: 0 fetch, 1 exec, 2 fault
    int         m_st  = 0;
    logic [4:0] m_xpt = '0;
    logic [7:0] m_src = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic w, input logic pr,
                         input logic p2, input logic [7:0] db);
        if (r) begin
            m_st  = 0;
            m_xpt = 5'd0;
            m_src = 8'h00;
        end else if (m_st == 2 || w) begin
            // frozen
        end else if (m_st == 0) begin
            if (m_xpt == 5'd2) m_src = db;
            if (m_xpt == 5'd3) begin
                m_xpt = 5'd4;
                m_st  = 1;
            end else begin
                m_xpt = m_xpt + 5'd1;
            end
        end else begin
            if (pr || p2) begin
                m_xpt = 5'd0;
                if (p2) m_st = 0;
            end else if (m_xpt == 5'd31) begin
                m_st = 2;
            end else begin
                m_xpt = m_xpt + 5'd1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic pr,
                       input logic p2, input logic [7:0] db);
        exp_t       e;
        logic [4:0] nx;
        logic [7:0] ns;
        reset        = r;
        Wait         = w;
        PR_Reset_XPT = pr;
        P2_Set_CM1   = p2;
        DataBus      = db;
        model(r, w, pr, p2, db);
        e.xpt = m_xpt;
        e.src = m_src;
        e.cm1 = (m_st == 0);
        e.en  = (m_st == 1);
        e.flt = (m_st == 2);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e  = sb.pop_front();
            nx = ~e.xpt;
            ns = ~e.src;
            chk("xpt", XPT, e.xpt);
            chk("not_xpt", notXPT, nx);
            chk("src", Source, e.src);
            chk("not_src", notSource, ns);
            chk("cm1", CM1, e.cm1);
            chk("enable", enable, e.en);
            chk("fault", Fault, e.flt);
        end
    endtask

    initial begin
        // reset
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 1, 1, 1, 8'h33);
        chk("rst_xpt", XPT, 5'd0);
        chk("rst_nxpt", notXPT, 5'h1F);
        chk("rst_nsrc", notSource, 8'hFF);
        chk("rst_cm1", CM1, 1'b1);

        // fetch FF, exec to 10, both strobes
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'hFF);
        chk("f_xpt3", XPT, 5'd3);
        chk("f_src", Source, 8'hFF);
        chk("f_nsrc", notSource, 8'h00);
        chk("f_cm1", CM1, 1'b1);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 8'h11);
        chk("e_xpt10", XPT, 5'd10);
        chk("e_en", enable, 1'b1);
        chk("e_src_hold", Source, 8'hFF);
        cyc(0, 0, 1, 1, 8'h11);
        chk("both_xpt", XPT, 5'd0);
        chk("both_cm1", CM1, 1'b1);
        chk("both_en", enable, 1'b0);

        // wait during latch step
        cyc(0, 0, 0, 0, 8'h22);
        cyc(0, 0, 0, 0, 8'h22);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'hC7);
        cyc(0, 1, 0, 0, 8'hC7);
        chk("w_xpt", XPT, 5'd2);
        chk("w_src", Source, 8'hFF);
        cyc(0, 0, 0, 0, 8'hC7);
        chk("w_rel_xpt", XPT, 5'd3);
        chk("w_rel_src", Source, 8'hC7);
        chk("w_rel_nsrc", notSource, 8'h38);

        // PR_Reset_XPT only at step 6
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00);
        chk("pr_pre", XPT, 5'd6);
        cyc(0, 0, 1, 0, 8'h00);
        chk("pr_xpt", XPT, 5'd0);
        chk("pr_nxpt", notXPT, 5'h1F);
        chk("pr_en", enable, 1'b1);
        chk("pr_src", Source, 8'hC7);

        // strobes held under wait at step 10
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 1, 8'h00);
        cyc(0, 1, 1, 1, 8'h00);
        chk("ws_xpt", XPT, 5'd10);
        chk("ws_en", enable, 1'b1);
        cyc(0, 0, 1, 1, 8'h00);
        chk("ws_rel_xpt", XPT, 5'd0);
        chk("ws_rel_cm1", CM1, 1'b1);

        // overflow into fault
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 8'h5A);
        for (int i = 0; i < 27; i++) cyc(0, 0, 0, 0, 8'h00);
        chk("ov_xpt31", XPT, 5'd31);
        chk("ov_en", enable, 1'b1);
        cyc(0, 0, 0, 0, 8'h00);
        chk("ov_fault", Fault, 1'b1);
        chk("ov_en0", enable, 1'b0);
        chk("ov_xpt", XPT, 5'd31);
        for (int i = 0; i < 12; i++)
            cyc(0, i[1], i[0], ~i[0], 8'h00);
        chk("ov_sticky", Fault, 1'b1);
        chk("ov_sticky_x", XPT, 5'd31);
        cyc(1, 0, 0, 0, 8'h00);
        chk("ov_rst_xpt", XPT, 5'd0);
        chk("ov_rst_cm1", CM1, 1'b1);
        chk("ov_rst_flt", Fault, 1'b0);

        // reset mid-exec under wait
        cyc(0, 0, 0, 0, 8'hA5);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 8'hA5);
        chk("mr_pre", XPT, 5'd7);
        chk("mr_src", Source, 8'hA5);
        cyc(1, 1, 1, 0, 8'hA5);
        chk("mr_src0", Source, 8'h00);
        chk("mr_nsrc", notSource, 8'hFF);
        chk("mr_cm1", CM1, 1'b1);
        chk("mr_en", enable, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
